// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: hold / advance / redirect plus imem handshake.
// Optional build macro PC_SEQ_FETCH_CNT_EN adds a saturating fetch_count output.
module pc_sequencer #(
   parameter int unsigned     PC_W      = 10,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(10'h000),
   parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(10'h3F0)
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            trap,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   output logic            flush,
   output logic            misalign
`ifdef PC_SEQ_FETCH_CNT_EN
   ,
   output logic [15:0]     fetch_count
`endif
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      FETCH    = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic            misalign_nxt;
   logic            imem_req_nxt;
   logic            flush_nxt;
   logic            redirect_c;
   logic [PC_W-1:0] target_c;

   assign pc_plus4  = pc + PC_W'(4);
   assign imem_addr = pc;

   // State, PC and state-decoded handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= BOOT;
         pc       <= RESET_VEC;
         misalign <= 1'b0;
         imem_req <= 1'b0;
         flush    <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         misalign <= misalign_nxt;
         imem_req <= imem_req_nxt;
         flush    <= flush_nxt;
      end
   end

   // Next-state / next-PC selection; trap > jmp > br_taken > stall > advance
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      misalign_nxt = misalign;
      redirect_c   = 1'b0;
      target_c     = jmp ? jmp_target : br_target;

      case (state)
         BOOT: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            if (trap) begin
               redirect_c = 1'b1;
               pc_nxt     = TRAP_VEC;
            end else if (jmp || br_taken) begin
               redirect_c = 1'b1;
               if (target_c[1:0] != 2'b00) begin
                  pc_nxt       = TRAP_VEC;
                  misalign_nxt = 1'b1;
               end else begin
                  pc_nxt = target_c;
               end
            end else if (stall) begin
               pc_nxt = pc;
            end else if (imem_ack) begin
               pc_nxt = pc_plus4;
            end
         end
         REDIRECT: begin
            state_nxt = FETCH;
            if (trap) begin
               redirect_c = 1'b1;
               pc_nxt     = TRAP_VEC;
            end
         end
         default: begin
            state_nxt = BOOT;
            pc_nxt    = RESET_VEC;
         end
      endcase

      if (redirect_c) begin
         state_nxt = REDIRECT;
      end

      // Outputs are registered copies of the next-state decode
      imem_req_nxt = (state_nxt == FETCH);
      flush_nxt    = (state_nxt == REDIRECT);
   end

`ifdef PC_SEQ_FETCH_CNT_EN
   logic cnt_inc_c;

   assign cnt_inc_c = (state == FETCH) && imem_ack && !redirect_c;

   // Saturating count of accepted, non-redirected fetch cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count <= CNT_W'(0);
      end else if (cnt_inc_c && (fetch_count != {CNT_W{1'b1}})) begin
         fetch_count <= fetch_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps then randomized traffic vs. a behavioural model.
module tb_pc_sequencer;

   localparam int PCW  = 10;
   localparam int TRAP = 'h3F0;

   logic           clk = 1'b0;
   logic           reset;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_ack;
   logic           stall;
   logic           br_taken;
   logic [PCW-1:0] br_target;
   logic           jmp;
   logic [PCW-1:0] jmp_target;
   logic           trap;
   logic [PCW-1:0] pc;
   logic [PCW-1:0] pc_plus4;
   logic           flush;
   logic           misalign;
`ifdef PC_SEQ_FETCH_CNT_EN
   logic [15:0]    fetch_count;
`endif

   pc_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .trap       (trap),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .flush      (flush),
      .misalign   (misalign)
`ifdef PC_SEQ_FETCH_CNT_EN
      ,
      .fetch_count(fetch_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: booting / in-bubble flags, integer PC, sticky misalign, fetch count
   bit m_boot;
   bit m_bubble;
   bit m_mis;
   int m_pc;
   int m_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_boot   = 1'b1;
      m_bubble = 1'b0;
      m_mis    = 1'b0;
      m_pc     = 0;
      m_cnt    = 0;
   endtask

   task automatic model_edge();
      int tgt;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_bubble) begin
         if (trap) m_pc = TRAP;
         else      m_bubble = 1'b0;
      end else begin
         if (imem_ack && !(trap || jmp || br_taken) && m_cnt < 65535) m_cnt++;
         if (trap) begin
            m_pc = TRAP;
            m_bubble = 1'b1;
         end else if (jmp || br_taken) begin
            tgt = jmp ? int'(jmp_target) : int'(br_target);
            if (tgt % 4 != 0) begin
               m_pc  = TRAP;
               m_mis = 1'b1;
            end else begin
               m_pc = tgt;
            end
            m_bubble = 1'b1;
         end else if (!stall && imem_ack) begin
            m_pc = (m_pc + 4) % 1024;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},        16'(pc),        16'(m_pc));
      chk({tag, ".imem_addr"}, 16'(imem_addr), 16'(m_pc));
      chk({tag, ".pc_plus4"},  16'(pc_plus4),  16'((m_pc + 4) % 1024));
      chk({tag, ".imem_req"},  16'(imem_req),  16'(!m_boot && !m_bubble));
      chk({tag, ".flush"},     16'(flush),     16'(m_bubble));
      chk({tag, ".misalign"},  16'(misalign),  16'(m_mis));
`ifdef PC_SEQ_FETCH_CNT_EN
      chk({tag, ".fetch_count"}, fetch_count, 16'(m_cnt));
`endif
   endtask

   task automatic step(input string tag, input bit t, input bit j, input int jt,
                       input bit b, input int bt, input bit s, input bit a);
      trap       = t;
      jmp        = j;
      jmp_target = PCW'(jt);
      br_taken   = b;
      br_target  = PCW'(bt);
      stall      = s;
      imem_ack   = a;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed mid-cycle
   task automatic pulse_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      trap = 1'b0; jmp = 1'b0; br_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      jmp_target = '0; br_target = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b1;

      // Boot then sequential fetch with ack held high
      step("boot",  0, 0, 0, 0, 0, 0, 1);
      step("seq4",  0, 0, 0, 0, 0, 0, 1);
      step("seq8",  0, 0, 0, 0, 0, 0, 1);
      step("seqC",  0, 0, 0, 0, 0, 0, 1);
      step("noack", 0, 0, 0, 0, 0, 0, 0);

      // Wrap at top of PC space
      step("j3fc",  0, 1, 'h3FC, 0, 0, 0, 1);
      step("at3fc", 0, 0, 0, 0, 0, 0, 1);
      step("wrap",  0, 0, 0, 0, 0, 0, 1);

      // Stall holds PC for three cycles despite ack
      step("j010",  0, 1, 'h010, 0, 0, 0, 0);
      step("at010", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 0, 1, 1);
      step("unstall", 0, 0, 0, 0, 0, 0, 1);

      // jmp outranks br_taken in the same cycle
      step("j020",   0, 1, 'h020, 0, 0, 0, 0);
      step("at020",  0, 0, 0, 0, 0, 0, 0);
      step("jmpbr",  0, 1, 'h200, 1, 'h100, 1, 1);
      step("at200",  0, 0, 0, 0, 0, 0, 1);
      step("adv204", 0, 0, 0, 0, 0, 0, 1);

      // Misaligned target traps and sets sticky misalign
      step("mis",   0, 1, 'h102, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step("mis_hold", 0, 0, 0, 0, 0, 0, 1);
      step("brmis", 0, 0, 0, 1, 'h0A1, 0, 1);
      step("brmis2", 0, 0, 0, 0, 0, 0, 1);

      // Trap during redirect extends the bubble
      step("trap1",  1, 0, 0, 0, 0, 0, 1);
      step("trap2",  1, 1, 'h040, 1, 'h080, 0, 1);
      step("trapx",  0, 1, 'h040, 0, 0, 0, 1);
      step("trapf",  0, 0, 0, 0, 0, 0, 1);

      pulse_reset("midrst");

      // Five accepted fetches after reboot
      step("boot2", 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step("cnt", 0, 0, 0, 0, 0, 0, 1);
      step("cnt_idle", 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int jt;
         int bt;
         jt = int'($urandom_range(0, 1023));
         bt = int'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) jt = jt & 'h3FC;
         if ($urandom_range(0, 3) != 0) bt = bt & 'h3FC;
         step("rand",
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, jt,
              $urandom_range(0, 7) == 0, bt,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) pulse_reset("randrst");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RISC-V fetch stage. It owns the 10-bit word-aligned PC and decides each cycle whether to hold, advance by 4, or redirect to a branch, jump or trap target. It drives the instruction-memory request/acknowledge handshake and tells the pipeline when to flush the fetched slot.

## Interface
- PC_W, 10: PC width in bits; PC arithmetic is modulo 2^PC_W.
- RESET_VEC, 10'h000: PC value loaded on reset; word aligned.
- TRAP_VEC, 10'h3F0: PC value loaded on trap or misaligned target; word aligned.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address; always equal to pc.
- imem_ack  in  1  instruction memory accepted the request this cycle.
- stall  in  1  decode hazard; hold the PC.
- br_taken  in  1  a branch resolved as taken.
- br_target  in  PC_W  branch target.
- jmp  in  1  an unconditional jump (jal/jalr).
- jmp_target  in  PC_W  jump target.
- trap  in  1  an exception or illegal-instruction request.
- pc  out  PC_W  current fetch PC (registered).
- pc_plus4  out  PC_W  pc + 4, combinational, wraps modulo 2^PC_W.
- flush  out  1  kill the instruction in the fetch/decode slot.
- misalign  out  1  sticky flag: a redirect target had bits [1:0] != 0.

## Operation
- States: BOOT, FETCH, REDIRECT.
- **BOOT**
  - Entered on reset.
  - imem_req=0, flush=0.
  - Moves unconditionally to FETCH on the first clock edge after reset deasserts.
- **FETCH**
  - imem_req=1.
  - Event priority within the cycle: trap > jmp > br_taken > stall > advance.
  - trap: pc<=TRAP_VEC; go to REDIRECT.
  - jmp or br_taken: pc<=target; go to REDIRECT. If target[1:0]!=0, pc<=TRAP_VEC and misalign<=1 instead.
  - Redirects are taken whether or not imem_ack is high. Any outstanding request is abandoned.
  - stall with no redirect: hold pc; stay in FETCH.
  - imem_ack with no stall and no redirect: pc<=pc+4 (0x3FC wraps to 0x000).
  - No ack: hold pc and keep imem_req high.
- **REDIRECT**
  - imem_req=0, flush=1, for exactly one cycle.
  - br_taken, jmp and stall are ignored in this state.
  - trap is honoured: pc<=TRAP_VEC and the block stays in REDIRECT one more cycle.
  - Otherwise moves to FETCH.
- misalign is only cleared by reset.
- Asserting reset mid-operation immediately forces BOOT and all reset values.

## Timing
- Reset values: pc=RESET_VEC, state=BOOT, imem_req=0, flush=0, misalign=0, fetch_count=0.
- pc_plus4 reset value is RESET_VEC+4.
- imem_addr and pc are register outputs with no combinational path from any input.
- imem_req and flush are decoded from state only.
- Sequential advance: ack at edge k gives the new pc from edge k onward. Back-to-back acks give one instruction per cycle.
- Redirect latency:
  - Event sampled at edge k.
  - Cycle after k: pc=target, flush=1, imem_req=0.
  - Edge k+1: back in FETCH requesting the target.
  - Cost is exactly one bubble.
- A redirect in the same cycle as stall or ack: the redirect wins, and the ack'd instruction is flushed.

## Configuration
- PC_SEQ_FETCH_CNT_EN defined:
  - Adds output fetch_count[15:0].
  - Increments on every cycle with state=FETCH, imem_ack=1 and no redirect.
  - Saturates at 16'hFFFF and resets to 0.
- Undefined: no fetch_count port and no counter logic. All other behaviour is identical.

## Test plan
- Release reset; ack held high -> BOOT for 1 cycle, then imem_addr 0x000, 0x004, 0x008, 0x00C on consecutive cycles.
- pc=0x3FC, ack=1 -> pc=0x000, no flush; pc_plus4 at 0x3FC reads 0x000.
- pc=0x010: stall=1 for 3 cycles with ack=1 -> pc stays 0x010. Stall drops -> 0x014.
- pc=0x020: br_taken=1, br_target=0x100 and jmp=1, jmp_target=0x200 in the same cycle -> next cycle pc=0x200, flush=1, imem_req=0; then a fetch of 0x200.
- jmp_target=0x102 -> pc=0x3F0, misalign=1, and misalign stays 1 after later normal fetches until reset.
- trap during REDIRECT -> pc=0x3F0 and 2 total flush cycles. Reset pulsed mid-FETCH -> immediate pc=0x000, imem_req=0. With PC_SEQ_FETCH_CNT_EN: 5 acks -> fetch_count=5.
